// File: rtl/dcache_pkg.sv
// Shared DRAM-cache front-end types: Tag FIFO entry, rw encoding, issue FSM states, tag-field helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dcache_pkg;

   localparam int DC_ADDR_WIDTH   = 32;
   localparam int DC_DATA_WIDTH   = 64;
   localparam int DC_ID_WIDTH     = 4;
   localparam int DC_INDEX_WIDTH  = 12;
   localparam int DC_OFFSET_WIDTH = 6;
   localparam int DC_TID_WIDTH    = 2;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BRESP
   } state_t;

   // Tag FIFO entry as seen by the tag comparator (default widths).
   typedef struct packed {
      logic                    rw;
      logic [DC_TID_WIDTH-1:0]  tid;
      logic [DC_ADDR_WIDTH-1:0] addr;
   } tag_entry_t;

   // Mask that keeps index+offset bits and clears the tag field above them.
   function automatic logic [63:0] index_offset_mask(input int unsigned lsb_bits);
      return (64'd1 << lsb_bits) - 64'd1;
   endfunction

endpackage

// File: rtl/tag_probe_issue_rr_arb2.sv
// Two-requester round-robin arbiter; requester a wins first after reset.
// Latency: grant is combinational from requests; priority flag updates on the grant edge.
// Backpressure: a grant is assumed taken in the cycle it is given.
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   output logic grant_a,
   output logic grant_b
);

   logic last_a;

   assign grant_a = req_a && (!req_b || !last_a);
   assign grant_b = req_b && (!req_a ||  last_a);

   // Remember which side won last so the other side is preferred next time.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_a <= 1'b0;
      end else if (grant_a) begin
         last_a <= 1'b1;
      end else if (grant_b) begin
         last_a <= 1'b0;
      end
   end

endmodule

// File: rtl/tag_probe_issue.sv
// Accepts host reads/single-beat writes, allocates read TIDs and issues one tag probe per request.
// Latency: accept in S_IDLE, probe the next cycle; Tag FIFO/wbuffer push on the probe handshake.
// Backpressure: one request in flight; accepts blocked by afull inputs, full ROB, and non-idle state.
module tag_probe_issue
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH   = DC_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DC_DATA_WIDTH,
   parameter int ID_WIDTH     = DC_ID_WIDTH,
   parameter int INDEX_WIDTH  = DC_INDEX_WIDTH,
   parameter int OFFSET_WIDTH = DC_OFFSET_WIDTH,
   parameter int TID_WIDTH    = DC_TID_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ADDR_WIDTH-1:0]           s_araddr,
   input  logic [ID_WIDTH-1:0]             s_arid,
   input  logic                            s_arvalid,
   output logic                            s_arready_o,
   input  logic [ADDR_WIDTH-1:0]           s_awaddr,
   input  logic [ID_WIDTH-1:0]             s_awid,
   input  logic                            s_awvalid,
   output logic                            s_awready_o,
   input  logic [DATA_WIDTH-1:0]           s_wdata,
   input  logic                            s_wvalid,
   output logic                            s_wready_o,
   output logic [ID_WIDTH-1:0]             s_bid_o,
   output logic                            s_bvalid_o,
   input  logic                            s_bready_i,
   output logic [ADDR_WIDTH-1:0]           mc_araddr_o,
   output logic [ID_WIDTH-1:0]             mc_arid_o,
   output logic                            mc_arvalid_o,
   input  logic                            mc_arready_i,
   input  logic                            tag_fifo_afull_i,
   output logic                            tag_fifo_wren_o,
   output logic [TID_WIDTH+ADDR_WIDTH:0]   tag_fifo_data_o,
   input  logic                            wbuffer_afull_i,
   output logic                            wbuffer_wren_o,
   output logic [DATA_WIDTH-1:0]           wbuffer_data_o,
   output logic                            rob_alloc_valid_o,
   output logic [TID_WIDTH-1:0]            rob_alloc_tid_o,
   output logic [ID_WIDTH-1:0]             rob_alloc_id_o,
   input  logic                            rob_retire_i
);

   localparam logic [ADDR_WIDTH-1:0] KEEP_MASK =
      ADDR_WIDTH'(index_offset_mask(INDEX_WIDTH + OFFSET_WIDTH));
   localparam logic [TID_WIDTH:0]    RD_MAX    = {1'b1, {TID_WIDTH{1'b0}}};

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    rw_q;
   logic [TID_WIDTH-1:0]    tid_q;
   logic [TID_WIDTH-1:0]    tid_cnt;
   logic [TID_WIDTH:0]      rd_out;

   logic idle_ok, rd_req, wr_req, rd_gnt, wr_gnt, probe_hs, retire_ok;

   // afull is only looked at here; once accepted the push is guaranteed room.
   assign idle_ok   = rst_n && (state == S_IDLE) && !tag_fifo_afull_i;
   assign rd_req    = idle_ok && s_arvalid && (rd_out < RD_MAX);
   assign wr_req    = idle_ok && !wbuffer_afull_i && s_awvalid && s_wvalid;
   assign probe_hs  = rst_n && (state == S_ISSUE) && mc_arready_i;
   assign retire_ok = rob_retire_i && (rd_out != '0);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (rd_req),
      .req_b   (wr_req),
      .grant_a (rd_gnt),
      .grant_b (wr_gnt)
   );

   assign s_arready_o       = rd_gnt;
   assign s_awready_o       = wr_gnt;
   assign s_wready_o        = wr_gnt;
   assign rob_alloc_valid_o = rd_gnt;
   assign rob_alloc_tid_o   = tid_cnt;
   assign rob_alloc_id_o    = s_arid;

   assign mc_arvalid_o      = (state == S_ISSUE);
   assign mc_araddr_o       = addr_q & KEEP_MASK;
   assign mc_arid_o         = '0;
   assign tag_fifo_wren_o   = probe_hs;
   assign tag_fifo_data_o   = {rw_q, tid_q, addr_q};
   assign wbuffer_wren_o    = probe_hs && (rw_q == RW_WRITE);
   assign wbuffer_data_o    = data_q;
   assign s_bvalid_o        = (state == S_BRESP);
   assign s_bid_o           = id_q;

   // Request FSM: latch the winner, hold it for the probe, then post the write response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         addr_q <= '0;
         id_q   <= '0;
         data_q <= '0;
         rw_q   <= RW_READ;
         tid_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rd_gnt) begin
                  addr_q <= s_araddr;
                  id_q   <= s_arid;
                  rw_q   <= RW_READ;
                  tid_q  <= tid_cnt;
                  state  <= S_ISSUE;
               end else if (wr_gnt) begin
                  addr_q <= s_awaddr;
                  id_q   <= s_awid;
                  data_q <= s_wdata;
                  rw_q   <= RW_WRITE;
                  tid_q  <= '0;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mc_arready_i) begin
                  state <= (rw_q == RW_WRITE) ? S_BRESP : S_IDLE;
               end
            end
            S_BRESP: begin
               if (s_bready_i) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // TID allocation and outstanding-read count; simultaneous accept and retire cancel out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tid_cnt <= '0;
         rd_out  <= '0;
      end else begin
         tid_cnt <= tid_cnt + TID_WIDTH'(rd_gnt);
         case ({rd_gnt, retire_ok})
            2'b10:   rd_out <= rd_out + 1'b1;
            2'b01:   rd_out <= rd_out - 1'b1;
            default: rd_out <= rd_out;
         endcase
      end
   end

   // A retire with nothing outstanding means the ROB and this block disagree.
   assert property (@(posedge clk) disable iff (!rst_n) rob_retire_i |-> (rd_out != '0));

endmodule
